// File: rtl/apb_ucpd_rx_ordset_pkg.sv
// Shared constants for the UCPD receive ordered-set detector: K-codes, set encodings,
// FSM states and the K-code pattern table used by the matcher.
package apb_ucpd_rx_ordset_pkg;

    localparam logic [4:0] K_SYNC1 = 5'b11000;
    localparam logic [4:0] K_SYNC2 = 5'b10001;
    localparam logic [4:0] K_SYNC3 = 5'b00110;
    localparam logic [4:0] K_RST1  = 5'b00111;
    localparam logic [4:0] K_RST2  = 5'b11001;
    localparam logic [4:0] K_EOP   = 5'b01101;

    localparam int unsigned PRE_MIN_BITS_DEF = 16;

    typedef enum logic [2:0] {
        OS_SOP        = 3'd0,
        OS_SOP_P      = 3'd1,
        OS_SOP_PP     = 3'd2,
        OS_SOP_P_DBG  = 3'd3,
        OS_SOP_PP_DBG = 3'd4,
        OS_HRST       = 3'd5,
        OS_CRST       = 3'd6,
        OS_NONE       = 3'd7
    } ordset_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_SOP,
        S_DATA,
        S_DONE
    } state_t;

    // Word layout {k3,k2,k1,k0}: the first received K-code sits in the low 5 bits.
    function automatic logic [19:0] ordset_pattern(input logic [2:0] kind);
        logic [19:0] p;
        case (kind)
            3'd0:    p = {K_SYNC2, K_SYNC1, K_SYNC1, K_SYNC1};
            3'd1:    p = {K_SYNC3, K_SYNC3, K_SYNC1, K_SYNC1};
            3'd2:    p = {K_SYNC3, K_SYNC1, K_SYNC3, K_SYNC1};
            3'd3:    p = {K_SYNC3, K_RST2,  K_RST2,  K_SYNC1};
            3'd4:    p = {K_SYNC2, K_SYNC3, K_RST2,  K_SYNC1};
            3'd5:    p = {K_RST2,  K_RST1,  K_RST1,  K_RST1};
            3'd6:    p = {K_SYNC3, K_RST1,  K_SYNC1, K_RST1};
            default: p = '0;
        endcase
        return p;
    endfunction

    function automatic logic [2:0] kcode_hits(input logic [19:0] a, input logic [19:0] b);
        logic [2:0] n;
        n = '0;
        for (int unsigned j = 0; j < 4; j++) begin
            if (a[5*j +: 5] == b[5*j +: 5]) n = n + 3'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/apb_ucpd_ordset_match.sv
// Combinational ordered-set classifier: 3-of-4 K-code match, lowest encoding wins.
// Build option UCPD_RX_ORDSET_STRICT_EN requires all four K-codes to match.
module apb_ucpd_ordset_match
    import apb_ucpd_rx_ordset_pkg::*;
(
    input  logic [19:0] ordset_word,
    output logic [2:0]  kind,
    output logic        match
);

`ifdef UCPD_RX_ORDSET_STRICT_EN
    localparam logic [2:0] MIN_HITS = 3'd4;
`else
    localparam logic [2:0] MIN_HITS = 3'd3;
`endif

    // Scan from the highest encoding down so the lowest matching one is left in place.
    always_comb begin
        match = 1'b0;
        kind  = OS_NONE;
        for (int unsigned i = 0; i < 7; i++) begin
            if (kcode_hits(ordset_word, ordset_pattern(3'(6 - i))) >= MIN_HITS) begin
                match = 1'b1;
                kind  = 3'(6 - i);
            end
        end
    end

endmodule

// File: rtl/apb_ucpd_rx_ordset.sv
// UCPD RX ordered-set detector: preamble end, SOP/reset set matching, payload symbol slicing.
// Build option UCPD_RX_ORDSET_STRICT_EN selects 4-of-4 set matching in the matcher.
module apb_ucpd_rx_ordset
    import apb_ucpd_rx_ordset_pkg::*;
#(
    parameter int unsigned PRE_MIN_BITS = PRE_MIN_BITS_DEF
) (
    input  logic       ic_clk,
    input  logic       ic_rst_n,
    input  logic       ucpden,
    input  logic       rx_pre_en,
    input  logic       rx_sop_en,
    input  logic       rx_data_en,
    input  logic       rx_bit_vld,
    input  logic       rx_bit,
    output logic       rx_pre_cmplt,
    output logic       rx_sop_cmplt,
    output logic [2:0] rx_ordset,
    output logic       hrst_vld,
    output logic       crst_vld,
    output logic       eop_ok,
    output logic       rx_ordset_err,
    output logic       rx_sym_vld,
    output logic [4:0] rx_sym
);

    localparam logic [6:0] PRE_MIN = 7'(PRE_MIN_BITS);

    state_t      state, state_nxt;
    logic [6:0]  alt, alt_nxt;
    logic        prv, prv_nxt;
    logic [4:0]  cnt, cnt_nxt;
    logic [19:0] sh, sh_nxt;

    logic        pre_cmplt_nxt, sop_cmplt_nxt, hrst_nxt, crst_nxt;
    logic        eop_nxt, err_nxt, sym_vld_nxt;
    logic [2:0]  ordset_nxt;
    logic [4:0]  sym_nxt;

    logic        en_any, pre_break, set_full, sym_full;
    logic [19:0] shifted;
    logic [4:0]  sym_word;
    logic [2:0]  match_kind;
    logic        match_hit;

    // One shift register serves both the 20-bit set and the 5-bit payload symbols;
    // the newest five bits always sit at the top.
    assign en_any    = rx_pre_en | rx_sop_en | rx_data_en;
    assign shifted   = {rx_bit, sh[19:1]};
    assign sym_word  = shifted[19:15];
    assign pre_break = (state == S_PRE) && rx_bit_vld && (alt != '0) && (rx_bit == prv)
                       && !rx_bit && (alt >= PRE_MIN);
    assign set_full  = (state == S_SOP) && rx_bit_vld && (cnt == 5'd19);
    assign sym_full  = (state == S_DATA) && rx_bit_vld && (cnt == 5'd4);

    apb_ucpd_ordset_match u_match (
        .ordset_word (shifted),
        .kind        (match_kind),
        .match       (match_hit)
    );

    always_ff @(posedge ic_clk) begin
        if (!ic_rst_n || !ucpden) begin
            state         <= S_IDLE;
            alt           <= '0;
            prv           <= 1'b0;
            cnt           <= '0;
            sh            <= '0;
            rx_pre_cmplt  <= 1'b0;
            rx_sop_cmplt  <= 1'b0;
            rx_ordset     <= OS_NONE;
            hrst_vld      <= 1'b0;
            crst_vld      <= 1'b0;
            eop_ok        <= 1'b0;
            rx_ordset_err <= 1'b0;
            rx_sym_vld    <= 1'b0;
            rx_sym        <= '0;
        end else begin
            state         <= state_nxt;
            alt           <= alt_nxt;
            prv           <= prv_nxt;
            cnt           <= cnt_nxt;
            sh            <= sh_nxt;
            rx_pre_cmplt  <= pre_cmplt_nxt;
            rx_sop_cmplt  <= sop_cmplt_nxt;
            rx_ordset     <= ordset_nxt;
            hrst_vld      <= hrst_nxt;
            crst_vld      <= crst_nxt;
            eop_ok        <= eop_nxt;
            rx_ordset_err <= err_nxt;
            rx_sym_vld    <= sym_vld_nxt;
            rx_sym        <= sym_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        alt_nxt   = alt;
        prv_nxt   = prv;
        cnt_nxt   = cnt;
        sh_nxt    = sh;
        if (!en_any) begin
            state_nxt = S_IDLE;
            alt_nxt   = '0;
            prv_nxt   = 1'b0;
            cnt_nxt   = '0;
            sh_nxt    = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rx_pre_en) begin
                        state_nxt = S_PRE;
                        alt_nxt   = '0;
                        cnt_nxt   = '0;
                    end
                end
                S_PRE: begin
                    if (rx_bit_vld) begin
                        prv_nxt = rx_bit;
                        if (alt == '0) begin
                            alt_nxt = 7'd1;
                        end else if (rx_bit != prv) begin
                            alt_nxt = (alt == '1) ? alt : alt + 7'd1;
                        end else if (pre_break) begin
                            // The two zeros that broke the preamble open Sync-1.
                            state_nxt = S_SOP;
                            alt_nxt   = '0;
                            cnt_nxt   = 5'd2;
                            sh_nxt    = '0;
                        end else begin
                            alt_nxt = 7'd1;
                        end
                    end
                end
                S_SOP: begin
                    if (rx_bit_vld) begin
                        sh_nxt = shifted;
                        if (cnt == 5'd19) begin
                            cnt_nxt   = '0;
                            state_nxt = (match_hit && match_kind < OS_HRST) ? S_DATA : S_DONE;
                        end else begin
                            cnt_nxt = cnt + 5'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (rx_bit_vld) begin
                        sh_nxt = shifted;
                        if (cnt == 5'd4) begin
                            cnt_nxt = '0;
                            if (sym_word == K_EOP) state_nxt = S_DONE;
                        end else begin
                            cnt_nxt = cnt + 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        pre_cmplt_nxt = 1'b0;
        sop_cmplt_nxt = 1'b0;
        hrst_nxt      = 1'b0;
        crst_nxt      = 1'b0;
        eop_nxt       = 1'b0;
        err_nxt       = 1'b0;
        sym_vld_nxt   = 1'b0;
        ordset_nxt    = rx_ordset;
        sym_nxt       = rx_sym;
        if (en_any) begin
            pre_cmplt_nxt = pre_break;
            if (set_full) begin
                if (match_hit) begin
                    ordset_nxt = match_kind;
                    if (match_kind == OS_HRST) begin
                        hrst_nxt = 1'b1;
                        eop_nxt  = 1'b1;
                    end else if (match_kind == OS_CRST) begin
                        crst_nxt = 1'b1;
                        eop_nxt  = 1'b1;
                    end else begin
                        sop_cmplt_nxt = 1'b1;
                    end
                end else begin
                    err_nxt = 1'b1;
                    eop_nxt = 1'b1;
                end
            end
            if (sym_full) begin
                sym_nxt = sym_word;
                if (sym_word == K_EOP) eop_nxt = 1'b1;
                else sym_vld_nxt = 1'b1;
            end
        end
    end

endmodule
